// File: rtl/clks_alot_half_rate_tracker.sv
// Half-period measurement engine for the clks_alot recovery path.
// Measures every high and low half-period of the recovered clock in system
// clocks, band-checks each sample, block-averages in-band samples over a
// power-of-two depth, and tracks lock, pause and violation status.
module clks_alot_half_rate_tracker #(
  parameter int RATE_COUNTER_WIDTH       = 32,
  parameter int MAX_RATE_AVERAGING_DEPTH = 1024,
  parameter int MAX_AVG_DEPTH_WIDTH      = (MAX_RATE_AVERAGING_DEPTH > 1) ?
                                           $clog2(MAX_RATE_AVERAGING_DEPTH) : 1,
  parameter int LOCKIN_COUNTER_WIDTH     = 8,
  parameter int VIOLATION_COUNTER_WIDTH  = 8
) (
  input  logic                               sys_clk,
  input  logic                               sync_rst,
  input  logic                               clear_i,
  input  logic                               rising_edge_i,
  input  logic                               falling_edge_i,
  input  logic                               combine_halves_i,
  input  logic                               pausable_en_i,
  input  logic [MAX_AVG_DEPTH_WIDTH-1:0]     avg_depth_log2_i,
  input  logic [RATE_COUNTER_WIDTH-1:0]      minimum_band_minus_one_i,
  input  logic [RATE_COUNTER_WIDTH-1:0]      maximum_band_minus_one_i,
  input  logic [LOCKIN_COUNTER_WIDTH-1:0]    required_lockin_i,
  input  logic [RATE_COUNTER_WIDTH-1:0]      pause_limit_i,
  output logic [RATE_COUNTER_WIDTH-1:0]      high_rate_o,
  output logic [RATE_COUNTER_WIDTH-1:0]      low_rate_o,
  output logic                               rate_valid_o,
  output logic                               over_frequency_violation_o,
  output logic                               under_frequency_violation_o,
  output logic                               edge_collision_o,
  output logic                               locked_o,
  output logic                               pause_active_o,
  output logic [RATE_COUNTER_WIDTH-1:0]      pause_duration_o,
  output logic [VIOLATION_COUNTER_WIDTH-1:0] violation_count_o
);

  localparam int RCW      = RATE_COUNTER_WIDTH;
  localparam int MDW      = MAX_AVG_DEPTH_WIDTH;
  localparam int LCW      = LOCKIN_COUNTER_WIDTH;
  localparam int VCW      = VIOLATION_COUNTER_WIDTH;
  // Accumulator holds up to 2^MDW samples of RCW bits without overflow.
  localparam int ACCW     = RCW + MDW;
  // Sample counter must be able to hold the block length itself (2^depth).
  localparam int SCW      = MDW + 1;
  localparam int LOG2_MAX = (MAX_RATE_AVERAGING_DEPTH > 1) ?
                            $clog2(MAX_RATE_AVERAGING_DEPTH) : 0;
  localparam logic [MDW-1:0] DEPTH_MAX = MDW'(LOG2_MAX);

  // Accumulator slots: one per half plus the shared one for combined mode.
  localparam int ACC_HIGH = 0;
  localparam int ACC_LOW  = 1;
  localparam int ACC_COMB = 2;
  localparam int N_ACC    = 3;

  typedef enum logic [1:0] {
    ST_UNARMED,  // no reference edge yet; nothing is being timed
    ST_TRACK,    // timing the current half-period
    ST_PAUSED    // half exceeded the pause limit; next edge just restarts timing
  } track_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  track_state_e           r_state;
  logic [RCW-1:0]         r_cnt;
  logic                   r_pause_active;
  logic [RCW-1:0]         r_pause_duration;

  logic [ACCW-1:0]        r_acc   [N_ACC];
  logic [SCW-1:0]         r_scnt  [N_ACC];
  logic [MDW-1:0]         r_depth [N_ACC];
  logic                   r_combine_q;

  logic [RCW-1:0]         r_high_rate;
  logic [RCW-1:0]         r_low_rate;
  logic                   r_rate_valid;

  logic                   r_over;
  logic                   r_under;
  logic                   r_collision;
  logic [LCW-1:0]         r_lock_cnt;
  logic                   r_locked;
  logic [VCW-1:0]         r_viol_cnt;

  // ---------------------------------------------------------------------------
  // Edge decode and sample classification
  // ---------------------------------------------------------------------------
  logic                   w_clr;
  logic                   w_collision;
  logic                   w_single_edge;
  logic                   w_take_sample;
  logic                   w_is_high;
  logic                   w_over;
  logic                   w_under_sample;
  logic                   w_inband;
  logic                   w_pause_start;
  logic                   w_pause_viol;
  logic                   w_under;
  logic                   w_viol_event;
  logic                   w_toggle;
  logic [RCW-1:0]         w_cnt_inc;
  logic [RCW-1:0]         w_dur_inc;
  logic [LCW-1:0]         w_lock_cnt_next;
  logic [LCW-1:0]         w_lockin_req;
  logic [MDW-1:0]         w_depth_clamped;
  logic [N_ACC-1:0]       w_feed;

  assign w_clr          = sync_rst | clear_i;
  assign w_collision    = rising_edge_i & falling_edge_i;
  assign w_single_edge  = rising_edge_i ^ falling_edge_i;
  // Only a tracking counter closes a half; the arming edge and the edge that
  // ends a pause both restart timing without producing a sample.
  assign w_take_sample  = w_single_edge & (r_state == ST_TRACK);
  // A falling edge ends the high half.
  assign w_is_high      = falling_edge_i;

  // Over-frequency wins if the two bands are configured to overlap.
  assign w_over         = w_take_sample & (r_cnt <= minimum_band_minus_one_i);
  assign w_under_sample = w_take_sample & ~w_over & (r_cnt > maximum_band_minus_one_i);
  assign w_inband       = w_take_sample & ~w_over & ~w_under_sample;

  // Pause is declared at most once per half: only from the tracking state.
  assign w_pause_start  = (r_state == ST_TRACK) & ~(rising_edge_i | falling_edge_i) &
                          (pause_limit_i != '0) & (r_cnt >= pause_limit_i);
  assign w_pause_viol   = w_pause_start & ~pausable_en_i;
  assign w_under        = w_under_sample | w_pause_viol;
  assign w_viol_event   = w_over | w_under | w_collision;

  assign w_toggle       = combine_halves_i ^ r_combine_q;

  assign w_cnt_inc      = (r_cnt == '1) ? r_cnt : r_cnt + RCW'(1);
  assign w_dur_inc      = (r_pause_duration == '1) ? r_pause_duration
                                                   : r_pause_duration + RCW'(1);
  assign w_lock_cnt_next = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + LCW'(1);
  assign w_lockin_req   = (required_lockin_i == '0) ? LCW'(1) : required_lockin_i;
  assign w_depth_clamped = (avg_depth_log2_i > DEPTH_MAX) ? DEPTH_MAX : avg_depth_log2_i;

  // A sample toggle cycle is discarded from averaging: the accumulators clear.
  assign w_feed[ACC_HIGH] = w_inband & ~combine_halves_i & w_is_high  & ~w_toggle;
  assign w_feed[ACC_LOW]  = w_inband & ~combine_halves_i & ~w_is_high & ~w_toggle;
  assign w_feed[ACC_COMB] = w_inband &  combine_halves_i              & ~w_toggle;

  // ---------------------------------------------------------------------------
  // Per-accumulator next-sum, effective depth and block completion
  // ---------------------------------------------------------------------------
  logic [ACCW-1:0]        w_acc_sum    [N_ACC];
  logic [MDW-1:0]         w_depth_eff  [N_ACC];
  logic [SCW-1:0]         w_block_len  [N_ACC];
  logic [RCW-1:0]         w_avg        [N_ACC];
  logic [N_ACC-1:0]       w_block_done;

  // Compute what each accumulator would do if fed the current sample.
  // NOTE: every signal driven here is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < N_ACC; i++) begin
      // The first sample of a block uses the live depth; later samples use
      // the depth latched at block start.
      w_depth_eff[i]  = (r_scnt[i] == '0) ? w_depth_clamped : r_depth[i];
      w_acc_sum[i]    = r_acc[i] + ACCW'(r_cnt);
      w_block_len[i]  = SCW'(1) << w_depth_eff[i];
      w_block_done[i] = w_feed[i] & ((r_scnt[i] + SCW'(1)) == w_block_len[i]);
      w_avg[i]        = RCW'(w_acc_sum[i] >> w_depth_eff[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Half-period counter and pause tracking
  // ---------------------------------------------------------------------------
  // Arm on the first edge, time each half, declare and time pauses.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_state          <= ST_UNARMED;
      r_cnt            <= '0;
      r_pause_active   <= 1'b0;
      r_pause_duration <= '0;
    end else if (w_collision) begin
      // Ambiguous edge: drop the timing reference; the next edge re-arms.
      r_state        <= ST_UNARMED;
      r_cnt          <= '0;
      r_pause_active <= 1'b0;
    end else begin
      unique case (r_state)
        ST_UNARMED: begin
          if (w_single_edge) begin
            r_state <= ST_TRACK;
            r_cnt   <= RCW'(1);
          end
        end
        ST_TRACK: begin
          if (w_single_edge) begin
            r_cnt <= RCW'(1);
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_pause_start) begin
              r_state          <= ST_PAUSED;
              r_pause_active   <= 1'b1;
              r_pause_duration <= '0;
            end
          end
        end
        ST_PAUSED: begin
          if (w_single_edge) begin
            // Duration is left showing the length of the pause just ended.
            r_state        <= ST_TRACK;
            r_cnt          <= RCW'(1);
            r_pause_active <= 1'b0;
          end else begin
            r_cnt            <= w_cnt_inc;
            r_pause_duration <= w_dur_inc;
          end
        end
        default: begin
          r_state <= ST_UNARMED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Remember the previous combine setting to detect mode toggles.
  always_ff @(posedge sys_clk) begin
    r_combine_q <= combine_halves_i;
  end

  // ---------------------------------------------------------------------------
  // Block accumulators
  // ---------------------------------------------------------------------------
  // Accumulate in-band samples; clear each accumulator when its block completes.
  always_ff @(posedge sys_clk) begin
    if (w_clr || w_toggle) begin
      // NOTE: accumulators are a few flops, not RAM, so they are reset explicitly; clear and mode toggles must zero them.
      for (int i = 0; i < N_ACC; i++) begin
        r_acc[i]   <= '0;
        r_scnt[i]  <= '0;
        r_depth[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ACC; i++) begin
        if (w_feed[i]) begin
          if (r_scnt[i] == '0) begin
            r_depth[i] <= w_depth_clamped;
          end
          if (w_block_done[i]) begin
            r_acc[i]  <= '0;
            r_scnt[i] <= '0;
          end else begin
            r_acc[i]  <= w_acc_sum[i];
            r_scnt[i] <= r_scnt[i] + SCW'(1);
          end
        end
      end
    end
  end

  // Publish a new average whenever a block completes.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_high_rate  <= '0;
      r_low_rate   <= '0;
      r_rate_valid <= 1'b0;
    end else begin
      if (w_block_done[ACC_HIGH]) begin
        r_high_rate <= w_avg[ACC_HIGH];
      end
      if (w_block_done[ACC_LOW]) begin
        r_low_rate <= w_avg[ACC_LOW];
      end
      if (w_block_done[ACC_COMB]) begin
        r_high_rate <= w_avg[ACC_COMB];
        r_low_rate  <= w_avg[ACC_COMB];
      end
      if (|w_block_done) begin
        r_rate_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Violations and lock
  // ---------------------------------------------------------------------------
  // Register violation pulses, count them saturating, and maintain lock.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_over      <= 1'b0;
      r_under     <= 1'b0;
      r_collision <= 1'b0;
      r_viol_cnt  <= '0;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_over      <= w_over;
      r_under     <= w_under;
      r_collision <= w_collision;
      if (w_viol_event && (r_viol_cnt != '1)) begin
        r_viol_cnt <= r_viol_cnt + VCW'(1);
      end
      if (w_viol_event) begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else if (w_inband) begin
        r_lock_cnt <= w_lock_cnt_next;
        r_locked   <= (w_lock_cnt_next >= w_lockin_req);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign high_rate_o                 = r_high_rate;
  assign low_rate_o                  = r_low_rate;
  assign rate_valid_o                = r_rate_valid;
  assign over_frequency_violation_o  = r_over;
  assign under_frequency_violation_o = r_under;
  assign edge_collision_o            = r_collision;
  assign locked_o                    = r_locked;
  assign pause_active_o              = r_pause_active;
  assign pause_duration_o            = r_pause_duration;
  assign violation_count_o           = r_viol_cnt;

endmodule

// File: tb/tb_clks_alot_half_rate_tracker.sv
// Self-checking bench for clks_alot_half_rate_tracker: directed scenarios
// plus randomized edge streams, every cycle compared against a timestamp
// based reference model.
module tb_clks_alot_half_rate_tracker;

  localparam int RCW     = 16;
  localparam int MAXD    = 16;
  localparam int MDW     = 4;
  localparam int LOG2MAX = 4;
  localparam int LCW     = 8;
  localparam int VCW     = 8;
  localparam longint RMAX = (longint'(1) << RCW) - 1;
  localparam longint VMAX = (longint'(1) << VCW) - 1;

  logic            sys_clk;
  logic            sync_rst;
  logic            clear_i;
  logic            rising_edge_i;
  logic            falling_edge_i;
  logic            combine_halves_i;
  logic            pausable_en_i;
  logic [MDW-1:0]  avg_depth_log2_i;
  logic [RCW-1:0]  minimum_band_minus_one_i;
  logic [RCW-1:0]  maximum_band_minus_one_i;
  logic [LCW-1:0]  required_lockin_i;
  logic [RCW-1:0]  pause_limit_i;
  logic [RCW-1:0]  high_rate_o;
  logic [RCW-1:0]  low_rate_o;
  logic            rate_valid_o;
  logic            over_frequency_violation_o;
  logic            under_frequency_violation_o;
  logic            edge_collision_o;
  logic            locked_o;
  logic            pause_active_o;
  logic [RCW-1:0]  pause_duration_o;
  logic [VCW-1:0]  violation_count_o;

  clks_alot_half_rate_tracker #(
    .RATE_COUNTER_WIDTH       (RCW),
    .MAX_RATE_AVERAGING_DEPTH (MAXD),
    .MAX_AVG_DEPTH_WIDTH      (MDW),
    .LOCKIN_COUNTER_WIDTH     (LCW),
    .VIOLATION_COUNTER_WIDTH  (VCW)
  ) dut (
    .sys_clk                     (sys_clk),
    .sync_rst                    (sync_rst),
    .clear_i                     (clear_i),
    .rising_edge_i               (rising_edge_i),
    .falling_edge_i              (falling_edge_i),
    .combine_halves_i            (combine_halves_i),
    .pausable_en_i               (pausable_en_i),
    .avg_depth_log2_i            (avg_depth_log2_i),
    .minimum_band_minus_one_i    (minimum_band_minus_one_i),
    .maximum_band_minus_one_i    (maximum_band_minus_one_i),
    .required_lockin_i           (required_lockin_i),
    .pause_limit_i               (pause_limit_i),
    .high_rate_o                 (high_rate_o),
    .low_rate_o                  (low_rate_o),
    .rate_valid_o                (rate_valid_o),
    .over_frequency_violation_o  (over_frequency_violation_o),
    .under_frequency_violation_o (under_frequency_violation_o),
    .edge_collision_o            (edge_collision_o),
    .locked_o                    (locked_o),
    .pause_active_o              (pause_active_o),
    .pause_duration_o            (pause_duration_o),
    .violation_count_o           (violation_count_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works on edge timestamps and running sums per block.
  // ---------------------------------------------------------------------------
  longint m_t = 0;
  bit     m_armed, m_paused, m_comb_prev;
  longint m_last;
  longint m_sum [3];
  int     m_n   [3];
  int     m_d   [3];
  int     m_consec;
  longint e_hi, e_lo, e_pdur, e_vcnt;
  bit     e_valid, e_over, e_under, e_coll, e_locked, e_pact;

  task automatic model_clear_blocks();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0;
      m_n[i]   = 0;
      m_d[i]   = 0;
    end
  endtask

  task automatic model_violation();
    if (e_vcnt < VMAX) e_vcnt++;
    m_consec = 0;
    e_locked = 1'b0;
  endtask

  // Block of 2^depth samples; the published rate is the floor of the mean.
  task automatic model_add(input int i, input longint s);
    longint blk;
    if (m_n[i] == 0) m_d[i] = (int'(avg_depth_log2_i) > LOG2MAX) ? LOG2MAX : int'(avg_depth_log2_i);
    m_sum[i] += s;
    m_n[i]++;
    blk = longint'(1) << m_d[i];
    if (m_n[i] == blk) begin
      if (i == 2)      begin e_hi = m_sum[i] / blk; e_lo = e_hi; end
      else if (i == 0) e_hi = m_sum[i] / blk;
      else             e_lo = m_sum[i] / blk;
      e_valid  = 1'b1;
      m_sum[i] = 0;
      m_n[i]   = 0;
    end
  endtask

  task automatic model_step();
    bit     toggled;
    longint s;
    longint req;
    m_t++;
    e_over  = 1'b0;
    e_under = 1'b0;
    e_coll  = 1'b0;
    if (sync_rst || clear_i) begin
      m_armed = 0; m_paused = 0; m_last = 0; m_consec = 0;
      e_hi = 0; e_lo = 0; e_pdur = 0; e_vcnt = 0;
      e_valid = 0; e_locked = 0; e_pact = 0;
      model_clear_blocks();
      m_comb_prev = combine_halves_i;
      return;
    end
    toggled     = (combine_halves_i != m_comb_prev);
    m_comb_prev = combine_halves_i;
    if (toggled) model_clear_blocks();
    if (rising_edge_i && falling_edge_i) begin
      e_coll = 1'b1;
      model_violation();
      m_armed  = 0;
      m_paused = 0;
      e_pact   = 0;
    end else if (rising_edge_i || falling_edge_i) begin
      if (!m_armed) begin
        m_armed = 1;
        m_last  = m_t;
      end else if (m_paused) begin
        m_paused = 0;
        e_pact   = 0;
        m_last   = m_t;
      end else begin
        s = m_t - m_last;
        if (s > RMAX) s = RMAX;
        m_last = m_t;
        if (s <= longint'(minimum_band_minus_one_i)) begin
          e_over = 1'b1;
          model_violation();
        end else if (s > longint'(maximum_band_minus_one_i)) begin
          e_under = 1'b1;
          model_violation();
        end else begin
          m_consec++;
          req = (required_lockin_i == 0) ? 1 : longint'(required_lockin_i);
          e_locked = (m_consec >= req);
          if (!toggled) model_add(combine_halves_i ? 2 : (falling_edge_i ? 0 : 1), s);
        end
      end
    end else if (m_paused) begin
      if (e_pdur < RMAX) e_pdur++;
    end else if (m_armed && pause_limit_i != 0 && (m_t - m_last) >= longint'(pause_limit_i)) begin
      m_paused = 1;
      e_pact   = 1;
      e_pdur   = 0;
      if (!pausable_en_i) begin
        e_under = 1'b1;
        model_violation();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit  next_fall = 0;
  int  n_under_seen;
  int  max_pdur_seen;
  bit  pact_seen;

  task automatic tick(input logic rise, input logic fall);
    rising_edge_i  = rise;
    falling_edge_i = fall;
    @(posedge sys_clk);
    model_step();
    #1;
    check("high_rate", high_rate_o, e_hi);
    check("low_rate", low_rate_o, e_lo);
    check("rate_valid", rate_valid_o, e_valid);
    check("over_pulse", over_frequency_violation_o, e_over);
    check("under_pulse", under_frequency_violation_o, e_under);
    check("collision", edge_collision_o, e_coll);
    check("locked", locked_o, e_locked);
    check("pause_active", pause_active_o, e_pact);
    check("pause_duration", pause_duration_o, e_pdur);
    check("violation_count", violation_count_o, e_vcnt);
    if (under_frequency_violation_o) n_under_seen++;
    if (pause_active_o) begin
      pact_seen = 1;
      if (int'(pause_duration_o) > max_pdur_seen) max_pdur_seen = int'(pause_duration_o);
    end
    rising_edge_i  = 1'b0;
    falling_edge_i = 1'b0;
  endtask

  // Idle len-1 cycles then emit the next alternating edge: a half of len cycles.
  task automatic emit_half(input int len);
    for (int i = 0; i < len - 1; i++) tick(1'b0, 1'b0);
    if (next_fall) tick(1'b0, 1'b1);
    else           tick(1'b1, 1'b0);
    next_fall = ~next_fall;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick(1'b0, 1'b0);
    clear_i   = 1'b0;
    next_fall = 0;
    n_under_seen  = 0;
    max_pdur_seen = 0;
    pact_seen     = 0;
  endtask

  task automatic base_config();
    combine_halves_i         = 1'b0;
    pausable_en_i            = 1'b0;
    avg_depth_log2_i         = MDW'(2);
    minimum_band_minus_one_i = RCW'(7);
    maximum_band_minus_one_i = RCW'(12);
    required_lockin_i        = LCW'(3);
    pause_limit_i            = '0;
  endtask

  initial begin
    sync_rst = 1'b1; clear_i = 1'b0;
    rising_edge_i = 1'b0; falling_edge_i = 1'b0;
    base_config();
    m_comb_prev = 0;
    model_clear_blocks();

    // Reset state
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst_high_rate", high_rate_o, 0);
    check("rst_valid", rate_valid_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_vcount", violation_count_o, 0);
    sync_rst = 1'b0;

    // 10/10 square wave, depth 2, lockin 3
    emit_half(3);                                   // arms only
    check("sq_no_lock_on_arm", locked_o, 0);
    emit_half(10); emit_half(10);
    check("sq_unlocked_after_2", locked_o, 0);
    emit_half(10);
    check("sq_locked_after_3", locked_o, 1);
    emit_half(10); emit_half(10); emit_half(10);
    check("sq_valid_after_6", rate_valid_o, 0);
    emit_half(10);
    check("sq_high_rate", high_rate_o, 10);
    check("sq_valid", rate_valid_o, 1);
    emit_half(10);
    check("sq_low_rate", low_rate_o, 10);

    // Combined mode: 9,11,9,11 average 10
    combine_halves_i = 1'b1;
    do_clear();
    emit_half(4);
    emit_half(9); emit_half(11); emit_half(9); emit_half(11);
    check("comb_high", high_rate_o, 10);
    check("comb_low", low_rate_o, 10);
    check("comb_valid", rate_valid_o, 1);

    // Over-frequency half inside a locked stream
    combine_halves_i = 1'b0;
    do_clear();
    emit_half(4);
    for (int i = 0; i < 6; i++) emit_half(10);
    check("ovf_locked_before", locked_o, 1);
    emit_half(5);
    check("ovf_pulse", over_frequency_violation_o, 1);
    check("ovf_lock_drop", locked_o, 0);
    check("ovf_count", violation_count_o, 1);
    tick(1'b0, 1'b0);
    check("ovf_pulse_single", over_frequency_violation_o, 0);
    emit_half(9);
    emit_half(10);
    check("ovf_high_avg", high_rate_o, 10);
    check("ovf_low_avg", low_rate_o, 10);

    // Pause, not pausable
    pause_limit_i = RCW'(20);
    do_clear();
    emit_half(4);
    for (int i = 0; i < 4; i++) emit_half(10);
    emit_half(50);
    check("pz0_under_once", n_under_seen, 1);
    check("pz0_lock_drop", locked_o, 0);
    check("pz0_count", violation_count_o, 1);
    check("pz0_pause_end", pause_active_o, 0);
    check("pz0_pause_seen", pact_seen, 1);
    for (int i = 0; i < 4; i++) emit_half(10);
    check("pz0_high_avg", high_rate_o, 10);
    check("pz0_low_avg", low_rate_o, 10);

    // Pause, pausable
    pausable_en_i = 1'b1;
    do_clear();
    emit_half(4);
    for (int i = 0; i < 4; i++) emit_half(10);
    emit_half(50);
    check("pz1_duration", max_pdur_seen, 29);
    check("pz1_locked", locked_o, 1);
    check("pz1_no_under", n_under_seen, 0);
    check("pz1_count", violation_count_o, 0);
    check("pz1_pause_end", pause_active_o, 0);

    // Edge collision
    tick(1'b1, 1'b1);
    check("col_pulse", edge_collision_o, 1);
    check("col_count", violation_count_o, 1);
    check("col_lock_drop", locked_o, 0);
    tick(1'b0, 1'b0);
    check("col_pulse_single", edge_collision_o, 0);
    emit_half(10);                                  // re-arm only
    emit_half(10); emit_half(10);
    check("col_rearm_no_sample", locked_o, 0);
    emit_half(10);
    check("col_relock", locked_o, 1);
    pausable_en_i = 1'b0;
    pause_limit_i = '0;

    // Violation counter saturation
    do_clear();
    for (int i = 0; i < 257; i++) emit_half(3);
    check("sat_255", violation_count_o, 255);
    for (int i = 0; i < 44; i++) emit_half(3);
    check("sat_hold", violation_count_o, 255);

    // Reset mid-block
    do_clear();
    emit_half(4);
    for (int i = 0; i < 3; i++) emit_half(10);
    sync_rst = 1'b1;
    tick(1'b0, 1'b0);
    sync_rst = 1'b0;
    check("mid_rst_locked", locked_o, 0);
    check("mid_rst_vcount", violation_count_o, 0);
    check("mid_rst_rates", {high_rate_o, low_rate_o}, 0);
    next_fall = 0;

    // Randomized streams
    for (int r = 0; r < 10; r++) begin
      minimum_band_minus_one_i = RCW'($urandom_range(2, 7));
      maximum_band_minus_one_i = RCW'($urandom_range(11, 16));
      required_lockin_i        = LCW'($urandom_range(0, 4));
      pausable_en_i            = 1'($urandom_range(0, 1));
      pause_limit_i            = ($urandom_range(0, 2) == 0) ? '0 : RCW'($urandom_range(18, 35));
      combine_halves_i         = 1'($urandom_range(0, 1));
      avg_depth_log2_i         = MDW'($urandom_range(0, 15));
      do_clear();
      for (int k = 0; k < 80; k++) begin
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel < 3) begin
          tick(1'b1, 1'b1);
        end else begin
          if (sel < 6)       combine_halves_i = ~combine_halves_i;
          else if (sel < 12) avg_depth_log2_i = MDW'($urandom_range(0, 15));
          emit_half((sel >= 94) ? int'($urandom_range(20, 45)) : int'($urandom_range(2, 18)));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clks_alot_half_rate_tracker.md
# clks_alot_half_rate_tracker

Parametrised half-period measurement engine for the sir_clks_alot recovery path. It takes single-cycle recovered edge pulses and measures each high and low half-period in system clocks. It block-averages the measurements over a runtime-selectable power-of-two depth and band-checks every sample. It also produces the lock, pause and over/under-frequency status that feeds `recovered_half_rates_s` and `status_s`.

## Interface
- `RATE_COUNTER_WIDTH`, 32, width of half-period counters, bands and averaged rates
- `MAX_RATE_AVERAGING_DEPTH`, 1024, largest averaging block; power of 2 only
- `MAX_AVG_DEPTH_WIDTH`, `$clog2(MAX_RATE_AVERAGING_DEPTH)` (1 if depth is 1), width of depth selector
- `LOCKIN_COUNTER_WIDTH`, 8, width of consecutive-in-band counter
- `VIOLATION_COUNTER_WIDTH`, 8, width of saturating violation counter
- `sys_clk`  in  1  sole clock
- `sync_rst`  in  1  synchronous, active-high reset
- `clear_i`  in  1  same effect as reset on all state except config; reset and clear dominate all other inputs
- `rising_edge_i` / `falling_edge_i`  in  1 each  recovered edge pulses
- `combine_halves_i`  in  1  1 = even 50/50: one accumulator fed by both halves; both rate outputs show the same value
- `pausable_en_i`  in  1  1 = pauses are forwarded, not violations
- `avg_depth_log2_i`  in  `MAX_AVG_DEPTH_WIDTH`  block size = 2^value; values above log2(MAX) clamp
- `minimum_band_minus_one_i`, `maximum_band_minus_one_i`  in  `RATE_COUNTER_WIDTH`  band limits
- `required_lockin_i`  in  `LOCKIN_COUNTER_WIDTH`  consecutive in-band samples needed to lock; 0 treated as 1
- `pause_limit_i`  in  `RATE_COUNTER_WIDTH`  half-period length at which a pause is declared; 0 disables pause detection
- `high_rate_o`, `low_rate_o`  out  `RATE_COUNTER_WIDTH`  last completed block averages
- `rate_valid_o`  out  1  set after the first completed block; cleared by reset/clear
- `over_frequency_violation_o`, `under_frequency_violation_o`  out  1  single-cycle pulses
- `edge_collision_o`  out  1  pulse when both edge inputs are high in the same cycle
- `locked_o`  out  1  lock status
- `pause_active_o`  out  1  pause in progress
- `pause_duration_o`  out  `RATE_COUNTER_WIDTH`  cycles elapsed since pause declared, saturating
- `violation_count_o`  out  `VIOLATION_COUNTER_WIDTH`  saturating count of over, under and collision events

## Operation
- The half counter is unarmed after reset. The first edge arms it and loads 1; no sample is taken.
- While armed, the counter increments every cycle and saturates at all-ones. Each edge closes the current half: sample = counter value, then the counter reloads to 1.
- A falling edge closes a high half; a rising edge closes a low half.
- Sample classification:
  - over-frequency if sample <= `minimum_band_minus_one_i`
  - under-frequency if sample > `maximum_band_minus_one_i`
  - otherwise in-band
- In-band sample: added to its accumulator (or the combined accumulator); lock counter increments, saturating. `locked_o` sets when lock counter >= max(`required_lockin_i`, 1).
- Out-of-band sample: not accumulated; violation pulse; lock counter and `locked_o` cleared; `violation_count_o`++.
- Accumulators are `RATE_COUNTER_WIDTH+MAX_AVG_DEPTH_WIDTH` wide. Each has a sample counter.
  - When the sample count reaches 2^depth, the rate output = accumulator >> depth (truncating).
  - On that update the accumulator and sample count clear. Depth is latched at block start; mid-block changes apply to the next block.
- Combined mode drives the same value on both rate outputs. Toggling `combine_halves_i` clears all accumulators; rate outputs hold their values.
- Pause: when an armed counter reaches `pause_limit_i`, `pause_active_o` sets and `pause_duration_o` counts from 0.
  - `pausable_en_i`=0: under-frequency pulse and lock drop, once per pause.
  - `pausable_en_i`=1: lock held and no violation.
- The next edge ends the pause and clears `pause_active_o`. It records no sample, no violation and no accumulator change, and reloads the counter to 1.
- Edge collision: both edges high in one cycle → `edge_collision_o` pulse, violation count++, lock drop. The counter is disarmed and the next edge re-arms it.

## Timing
- Every output resets to 0; the counter resets unarmed.
- Edge sampled at cycle N:
  - violation pulses, `locked_o`, `violation_count_o` and the cleared pause flag update at N+1
  - a block-completing sample updates the rate outputs and `rate_valid_o` at N+1
- Pause: `pause_active_o` rises the cycle after the counter equals `pause_limit_i`.
- Violation counter saturates at all-ones and does not wrap. The half counter saturates and does not wrap.

## Test plan
- Square wave, 10 high / 10 low, depth 2 (4 samples), band 8..12 (min_m1=7, max_m1=12), lockin 3 → first edge gives no sample; `locked_o` after the third in-band sample; `high_rate_o`=`low_rate_o`=10 with `rate_valid_o` after four samples of each half.
- Halves 9,11,9,11 with combine=1, depth 2 → both rate outputs = 10.
- One 5-cycle half inside a locked 10/10 stream → `over_frequency_violation_o` pulse at N+1; `locked_o`=0; count=1; averages unaffected.
- Hold input for 50 cycles, pause_limit 20: pausable=0 → one under pulse and lock drop; pausable=1 → `pause_active_o` set, `pause_duration_o` reaches 29, lock held, next edge clears pause and takes no sample.
- Both edge pulses in the same cycle → `edge_collision_o` pulse, count+1, next edge only re-arms.
- 300 violations with 8-bit counter → `violation_count_o` holds 255; `sync_rst` mid-block → all outputs 0 next cycle.
